addsub_split: RTL and testbench

ADDSUB_SPLIT -- requirements
Module: addsub_split

---
 rtl/addsub_split_if.sv | 24 ++
 rtl/addsub_split.sv | 151 +++++++++++++++
 tb/tb_addsub_split.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/addsub_split_if.sv
// Handshake bundle for addsub_split: Sum/Sub word input stream and recovered-operand output.
// The master modport is the side that supplies words and consumes results.
interface addsub_split_if #(parameter int N = 4);
   logic         in_valid;
   logic         in_ready;
   logic         in_sd;
   logic [N:0]   in_data;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] a_out;
   logic [N-1:0] b_out;
   logic         err_parity;
   logic         err_range;

   modport master (
      output in_valid, in_sd, in_data, out_ready,
      input  in_ready, out_valid, a_out, b_out, err_parity, err_range
   );

   modport slave (
      input  in_valid, in_sd, in_data, out_ready,
      output in_ready, out_valid, a_out, b_out, err_parity, err_range
   );
endinterface

// File: rtl/addsub_split.sv
// Recovers operands A and B from a Sum (A+B) / Sub (A-B) word pair.
// Words may arrive in either order; a repeated word of the same kind replaces the earlier one.
module addsub_split #(
   parameter int N = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   addsub_split_if.slave  bus
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      HAVE_SUM = 3'd1,
      HAVE_SUB = 3'd2,
      CALC     = 3'd3,
      DONE     = 3'd4
   } state_t;

   state_t       state_q, state_d;
   logic [N:0]   sum_q, sum_d;
   logic [N:0]   sub_q, sub_d;
   logic [N-1:0] a_q, a_d;
   logic [N-1:0] b_q, b_d;
   logic         par_q, par_d;
   logic         rng_q, rng_d;
   logic         vld_q, vld_d;
   logic         rdy_q, rdy_d;

   logic [N+1:0] s2_s, d2_s;
   logic [N+1:0] a_full_s, b_full_s;
   logic         xfer_s;

   // Top three bits all equal means the value fits in N signed bits.
   function automatic logic fits_n(input logic [N+1:0] v);
      return (v[N+1:N-1] == {3{1'b0}}) || (v[N+1:N-1] == {3{1'b1}});
   endfunction

   function automatic logic odd_lsb(input logic [N+1:0] v);
      return v[0];
   endfunction

   assign xfer_s   = bus.in_valid && rdy_q;
   assign s2_s     = {sum_q[N], sum_q} + {sub_q[N], sub_q};
   assign d2_s     = {sum_q[N], sum_q} - {sub_q[N], sub_q};
   assign a_full_s = {s2_s[N+1], s2_s[N+1:1]};
   assign b_full_s = {d2_s[N+1], d2_s[N+1:1]};

   // Next-state, pair capture and result computation.
   always_comb begin
      state_d = state_q;
      sum_d   = sum_q;
      sub_d   = sub_q;
      a_d     = a_q;
      b_d     = b_q;
      par_d   = par_q;
      rng_d   = rng_q;
      case (state_q)
         IDLE: begin
            if (xfer_s) begin
               if (bus.in_sd) begin
                  sub_d   = bus.in_data;
                  state_d = HAVE_SUB;
               end else begin
                  sum_d   = bus.in_data;
                  state_d = HAVE_SUM;
               end
            end else begin
               state_d = IDLE;
            end
         end
         HAVE_SUM: begin
            if (xfer_s) begin
               if (bus.in_sd) begin
                  sub_d   = bus.in_data;
                  state_d = CALC;
               end else begin
                  sum_d   = bus.in_data;
                  state_d = HAVE_SUM;
               end
            end else begin
               state_d = HAVE_SUM;
            end
         end
         HAVE_SUB: begin
            if (xfer_s) begin
               if (bus.in_sd) begin
                  sub_d   = bus.in_data;
                  state_d = HAVE_SUB;
               end else begin
                  sum_d   = bus.in_data;
                  state_d = CALC;
               end
            end else begin
               state_d = HAVE_SUB;
            end
         end
         CALC: begin
            a_d     = a_full_s[N-1:0];
            b_d     = b_full_s[N-1:0];
            par_d   = odd_lsb(s2_s);
            rng_d   = !(fits_n(a_full_s) && fits_n(b_full_s));
            state_d = DONE;
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      rdy_d = (state_d == IDLE) || (state_d == HAVE_SUM) || (state_d == HAVE_SUB);
      vld_d = (state_d == DONE);
   end

   // State, operand words and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sum_q   <= {(N+1){1'b0}};
         sub_q   <= {(N+1){1'b0}};
         a_q     <= {N{1'b0}};
         b_q     <= {N{1'b0}};
         par_q   <= 1'b0;
         rng_q   <= 1'b0;
         vld_q   <= 1'b0;
         rdy_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         sum_q   <= sum_d;
         sub_q   <= sub_d;
         a_q     <= a_d;
         b_q     <= b_d;
         par_q   <= par_d;
         rng_q   <= rng_d;
         vld_q   <= vld_d;
         rdy_q   <= rdy_d;
      end
   end

   assign bus.in_ready   = rdy_q;
   assign bus.out_valid  = vld_q;
   assign bus.a_out      = a_q;
   assign bus.b_out      = b_q;
   assign bus.err_parity = par_q;
   assign bus.err_range  = rng_q;

endmodule

// File: tb/tb_addsub_split.sv
// Scoreboard bench for addsub_split at N=4: expectations are queued as pairs are sent
// and checked against each delivered result.
module tb_addsub_split;

   localparam int N = 4;

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic       par;
      logic       rng;
   } exp_t;

   logic clk;
   logic rst_n;
   int   err_cnt;
   int   chk_cnt;
   exp_t sb[$];

   addsub_split_if #(.N(N)) ifc ();

   addsub_split #(.N(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input int sum, input int sub);
      exp_t e;
      int   s, d, av, bv;
      logic [31:0] av_v, bv_v;
      s  = sum + sub;
      d  = sum - sub;
      av = s >>> 1;
      bv = d >>> 1;
      av_v  = av;
      bv_v  = bv;
      e.a   = av_v[3:0];
      e.b   = bv_v[3:0];
      e.par = (s % 2) != 0;
      e.rng = (av < -8) || (av > 7) || (bv < -8) || (bv > 7);
      sb.push_back(e);
   endtask

   // Present one word and hold it until a transfer edge happens.
   task automatic send(input logic sd, input int d);
      logic [31:0] dv;
      int          waited;
      dv = d;
      @(negedge clk);
      ifc.in_valid = 1'b1;
      ifc.in_sd    = sd;
      ifc.in_data  = dv[4:0];
      waited = 0;
      while (!ifc.in_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (!ifc.in_ready) check_val("send_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      ifc.in_valid = 1'b0;
      ifc.in_data  = 5'b10101;
   endtask

   // Wait for a result, check latency and values, optionally stall the output.
   task automatic collect(input int hold);
      int   cycles;
      exp_t e;
      logic [3:0] a0, b0;
      cycles = 0;
      ifc.out_ready = (hold == 0);
      @(negedge clk);
      cycles = 1;
      while (!ifc.out_valid && cycles < 20) begin
         @(negedge clk);
         cycles++;
      end
      check_val("latency", cycles, 32'd2);
      if (!ifc.out_valid) begin
         check_val("out_timeout", 32'd0, 32'd1);
         ifc.out_ready = 1'b1;
         return;
      end
      if (sb.size() == 0) begin
         check_val("sb_empty", 32'd0, 32'd1);
         return;
      end
      e = sb.pop_front();
      check_val("a_out", ifc.a_out, e.a);
      check_val("b_out", ifc.b_out, e.b);
      check_val("err_parity", ifc.err_parity, e.par);
      check_val("err_range", ifc.err_range, e.rng);
      check_val("ready_done", ifc.in_ready, 32'd0);
      a0 = ifc.a_out;
      b0 = ifc.b_out;
      for (int i = 0; i < hold; i++) begin
         ifc.in_valid = (i % 2) == 0;
         ifc.in_sd    = i[0];
         ifc.in_data  = 5'b01111;
         @(negedge clk);
         check_val("hold_valid", ifc.out_valid, 32'd1);
         check_val("hold_a", ifc.a_out, a0);
         check_val("hold_b", ifc.b_out, b0);
         check_val("hold_ready", ifc.in_ready, 32'd0);
      end
      ifc.in_valid  = 1'b0;
      ifc.out_ready = 1'b1;
      @(negedge clk);
      check_val("release_valid", ifc.out_valid, 32'd0);
      check_val("release_ready", ifc.in_ready, 32'd1);
   endtask

   task automatic pair(input int sum, input int sub, input logic sub_first);
      push_exp(sum, sub);
      if (sub_first) begin
         send(1'b1, sub);
         send(1'b0, sum);
      end else begin
         send(1'b0, sum);
         send(1'b1, sub);
      end
   endtask

   initial begin
      int   sv, dv;
      logic stray;
      err_cnt       = 0;
      chk_cnt       = 0;
      rst_n         = 1'b0;
      ifc.in_valid  = 1'b0;
      ifc.in_sd     = 1'b0;
      ifc.in_data   = 5'b00000;
      ifc.out_ready = 1'b1;
      #1;
      check_val("rst_valid", ifc.out_valid, 32'd0);
      check_val("rst_a", ifc.a_out, 32'd0);
      check_val("rst_b", ifc.b_out, 32'd0);
      check_val("rst_par", ifc.err_parity, 32'd0);
      check_val("rst_rng", ifc.err_range, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check_val("idle_ready", ifc.in_ready, 32'd1);

      pair(5, -3, 1'b0);
      collect(0);
      pair(5, -3, 1'b1);
      collect(0);
      send(1'b0, 7);
      pair(5, -3, 1'b0);
      collect(0);
      pair(3, 0, 1'b0);
      collect(0);
      pair(15, 1, 1'b0);
      collect(5);

      // Reset while holding a Sum: the pending word must be forgotten.
      send(1'b0, 5);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_val("mid_rst_valid", ifc.out_valid, 32'd0);
      check_val("mid_rst_a", ifc.a_out, 32'd0);
      check_val("mid_rst_b", ifc.b_out, 32'd0);
      check_val("mid_rst_rng", ifc.err_range, 32'd0);
      check_val("mid_rst_ready", ifc.in_ready, 32'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      send(1'b1, -3);
      stray = 1'b0;
      repeat (4) begin
         @(negedge clk);
         stray = stray | ifc.out_valid;
      end
      check_val("no_stray_out", stray, 32'd0);
      push_exp(5, -3);
      send(1'b0, 5);
      collect(0);

      pair(-16, 0, 1'b1);
      collect(0);

      for (int k = 0; k < 20; k++) begin
         sv = $urandom_range(31) - 16;
         dv = $urandom_range(31) - 16;
         pair(sv, dv, $urandom_range(1) == 1);
         collect((k % 4 == 3) ? 2 : 0);
      end

      check_val("sb_drained", sb.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
